syncfifo_writer: RTL and testbench

Write side of the synchronous FIFO: accepts messages on a val/rdy enqueue port, stores them in a power-of-two register-file array, and advances an extended (wrap-bit) write pointer. It sits directly upstream of the FIFO read-pointer stage. It exports `w_ptr` to that stage and takes its `r_ptr` back to compute full, almost-full and occupancy. It also provides the combinational read port of the storage array, which the dequeue side addresses with `r_ptr`.

---
 rtl/syncfifo_pkg.sv | 29 ++
 rtl/syncfifo_storage.sv | 32 +++
 rtl/syncfifo_writer.sv | 102 ++++++++++
 tb/tb_syncfifo_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syncfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syncfifo_pkg
// Description : Shared pointer math and parameter checks for the sync FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package syncfifo_pkg;

    // Full: wrap bits differ while the index bits match.
    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp, input int pw);
        logic [31:0] idx_mask;
        idx_mask = (32'd1 << (pw - 1)) - 32'd1;
        return (wp[pw-1] != rp[pw-1]) && (((wp ^ rp) & idx_mask) == 32'd0);
    endfunction

    function automatic logic [31:0] ptr_count(input logic [31:0] wp, input logic [31:0] rp, input int pw);
        return (wp - rp) & ((32'd1 << pw) - 32'd1);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

    function automatic bit af_thresh_legal(input int t, input int d);
        return (t >= 1) && (t <= d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/syncfifo_storage.sv
`default_nettype none
// ============================================================================
// Module      : syncfifo_storage
// Description : DEPTH x WIDTH flop array, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module syncfifo_storage #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/syncfifo_writer.sv
`default_nettype none
// ============================================================================
// Module      : syncfifo_writer
// Description : Write side of the sync FIFO: enqueue port, storage, extended
//               write pointer, full / almost-full / occupancy flags.
//               Optional high-watermark: SYNCFIFO_WRITER_PEAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module syncfifo_writer
    import syncfifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 32,
    parameter int PTR_WIDTH = $clog2(DEPTH) + 1,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [WIDTH-1:0]     recv_msg,
    input  logic [PTR_WIDTH-1:0] r_ptr,
    output logic [PTR_WIDTH-1:0] w_ptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH-1:0] count,
    input  logic [PTR_WIDTH-2:0] raddr,
    output logic [WIDTH-1:0]     rdata
`ifdef SYNCFIFO_WRITER_PEAK_EN
    ,
    output logic [PTR_WIDTH-1:0] peak,
    input  logic                 peak_clr
`endif
);

    localparam int c_idx_w = PTR_WIDTH - 1;

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $fatal(1, "syncfifo_writer: DEPTH must be a power of two >= 2");
    end
    if (!af_thresh_legal(AF_THRESH, DEPTH)) begin : g_bad_af
        $fatal(1, "syncfifo_writer: AF_THRESH must be in 1..DEPTH");
    end

    logic [PTR_WIDTH-1:0] r_wptr;
    logic [PTR_WIDTH-1:0] w_wptr_nxt;
    logic                 w_full;
    logic                 w_wen;

    assign w_full      = ptr_full(32'(r_wptr), 32'(r_ptr), PTR_WIDTH);
    assign w_wen       = recv_val & ~w_full;
    assign w_wptr_nxt  = r_wptr + {{(PTR_WIDTH-1){1'b0}}, w_wen};

    assign recv_rdy    = ~w_full;
    assign full        = w_full;
    assign w_ptr       = r_wptr;
    assign count       = PTR_WIDTH'(ptr_count(32'(r_wptr), 32'(r_ptr), PTR_WIDTH));
    assign almost_full = (count >= PTR_WIDTH'(AF_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
        end
    end

    syncfifo_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDX_W (c_idx_w)
    ) u_storage (
        .clk   (clk),
        .we    (w_wen),
        .waddr (r_wptr[c_idx_w-1:0]),
        .wdata (recv_msg),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef SYNCFIFO_WRITER_PEAK_EN
    // Post-edge occupancy assumes the current r_ptr; a same-cycle read is
    // picked up on the following edge.
    logic [PTR_WIDTH-1:0] w_count_nxt;
    logic [PTR_WIDTH-1:0] r_peak;

    assign w_count_nxt = PTR_WIDTH'(ptr_count(32'(w_wptr_nxt), 32'(r_ptr), PTR_WIDTH));
    assign peak        = r_peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (peak_clr) begin
            r_peak <= w_count_nxt;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_syncfifo_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_syncfifo_writer
// Description : Self-checking bench for syncfifo_writer (DEPTH=4, AF_THRESH=3)
//               with a scoreboard on the dequeue data path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syncfifo_writer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int PW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             recv_val;
    logic             recv_rdy;
    logic [WIDTH-1:0] recv_msg;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_ptr;
    logic             full;
    logic             almost_full;
    logic [PW-1:0]    count;
    logic [PW-2:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [PW-1:0]    peak;
    logic             peak_clr;

    logic             pop;
    logic             peek_en;
    logic [PW-2:0]    peek_addr;

    logic [WIDTH-1:0] sbq [$];
    int               n_checks = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    syncfifo_writer #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PW),
        .AF_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .recv_val    (recv_val),
        .recv_rdy    (recv_rdy),
        .recv_msg    (recv_msg),
        .r_ptr       (r_ptr),
        .w_ptr       (w_ptr),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .raddr       (raddr),
        .rdata       (rdata)
`ifdef SYNCFIFO_WRITER_PEAK_EN
        ,
        .peak        (peak),
        .peak_clr    (peak_clr)
`endif
    );

`ifndef SYNCFIFO_WRITER_PEAK_EN
    assign peak = '0;
`endif

    // Minimal read stage: advances r_ptr on pop, reset together with the writer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= '0;
        else if (pop) r_ptr <= r_ptr + 3'd1;
    end
    assign raddr = peek_en ? peek_addr : r_ptr[PW-2:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dequeue monitor: compares presented data against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && pop) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got %0h expected none", rdata);
            end else begin
                logic [WIDTH-1:0] exp;
                exp = sbq.pop_front();
                if (rdata !== exp) begin
                    n_fail++;
                    $display("FAIL sb_rdata: got %0h expected %0h", rdata, exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] msgs [4];
        msgs[0] = 32'hA0A0_0001;
        msgs[1] = 32'hB0B0_0002;
        msgs[2] = 32'hC0C0_0003;
        msgs[3] = 32'hD0D0_0004;

        rst_n = 1'b0; recv_val = 1'b0; recv_msg = '0; pop = 1'b0;
        peek_en = 1'b0; peek_addr = '0; peak_clr = 1'b0;
        repeat (2) tick();
        chk("rst_w_ptr", w_ptr, 0);
        chk("rst_rdy", recv_rdy, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_peak", peak, 0);
        rst_n = 1'b1;
        tick();

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            recv_val = 1'b1; recv_msg = msgs[i];
            chk("fill_rdy", recv_rdy, 1);
            sbq.push_back(msgs[i]);
            tick();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1 >= 3) ? 1 : 0);
            chk("fill_full", full, (i == 3) ? 1 : 0);
        end
        chk("full_w_ptr", w_ptr, 3'b100);
        chk("full_rdy", recv_rdy, 0);

        // Push while full is held off
        recv_msg = 32'hDEAD_BEEF;
        tick();
        chk("hold_w_ptr", w_ptr, 3'b100);
        chk("hold_count", count, 4);
        chk("hold_rdata", rdata, msgs[0]);

        // Simultaneous enqueue and dequeue while full
        pop = 1'b1; recv_msg = 32'hE0E0_0005;
        chk("fd_rdy", recv_rdy, 0);
        tick();
        pop = 1'b0;
        chk("fd_w_ptr", w_ptr, 3'b100);
        chk("fd_count", count, 3);
        chk("fd_rdy_after", recv_rdy, 1);
        sbq.push_back(32'hE0E0_0005);
        tick();
        recv_val = 1'b0;
        chk("e_w_ptr", w_ptr, 3'b101);
        peek_en = 1'b1; peek_addr = 2'd0;
        #1;
        chk("e_rdata", rdata, 32'hE0E0_0005);
        peek_en = 1'b0;

        // Drain B, C, D, E
        pop = 1'b1;
        repeat (4) tick();
        pop = 1'b0;
        chk("drain_count", count, 0);

        // Streaming wrap-around with 1-cycle lag
        for (int k = 0; k < 20; k++) begin
            recv_val = 1'b1; recv_msg = 32'h5000_0000 + k;
            sbq.push_back(32'h5000_0000 + k);
            pop = (k > 0);
            tick();
            chk("stream_count", count, 1);
        end
        recv_val = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("stream_count_end", count, 0);
        chk("stream_w_ptr", w_ptr, 3'b001);
        chk("stream_sb_empty", sbq.size(), 0);

        // Asynchronous reset mid-burst
        recv_val = 1'b1;
        recv_msg = 32'hF000_0000; sbq.push_back(recv_msg); tick();
        recv_msg = 32'hF000_0001; sbq.push_back(recv_msg); tick();
        chk("burst_count", count, 2);
        recv_msg = 32'hF000_0002;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_w_ptr", w_ptr, 0);
        chk("arst_count", count, 0);
        chk("arst_peak", peak, 0);
        sbq.delete();
        tick();
        recv_val = 1'b0; rst_n = 1'b1;
        tick();
        chk("arst_lost", w_ptr, 0);

        recv_val = 1'b1; recv_msg = 32'h6060_0006; sbq.push_back(recv_msg);
        tick();
        recv_val = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("post_rst_count", count, 0);

`ifdef SYNCFIFO_WRITER_PEAK_EN
        for (int i = 0; i < 3; i++) begin
            recv_val = 1'b1; recv_msg = 32'h7000_0000 + i; sbq.push_back(recv_msg);
            tick();
        end
        recv_val = 1'b0; pop = 1'b1;
        repeat (3) tick();
        pop = 1'b0;
        chk("peak_fill3", peak, 3);
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        chk("peak_clr", peak, 0);
        recv_val = 1'b1; recv_msg = 32'h7100_0000; sbq.push_back(recv_msg);
        tick();
        recv_val = 1'b0;
        chk("peak_one", peak, 1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
`endif
        chk("final_sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
